switch_encoder: RTL and testbench

Parametrised successor to the front-panel 4-to-2 switch encoder in the vending machine datapath. It takes `N_IN` raw, asynchronous, bouncing switch/coin inputs, then synchronises and debounces each one. Each debounced rising edge is captured as a pending event. Pending events are presented to the vending FSM one at a time as a binary code over a valid/ready handshake, highest index first. The block also flags simultaneous presses and lost events, which the plain combinational encoder cannot.

---
 rtl/switch_encoder_pkg.sv | 20 ++
 rtl/switch_encoder_if.sv | 28 ++
 rtl/switch_encoder_debounce.sv | 62 ++++++
 rtl/switch_encoder.sv | 75 +++++++
 tb/tb_switch_encoder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/switch_encoder_pkg.sv
// Shared definitions for the switch encoder slice.
//   SW_N_IN_DEF / SW_DEB_DEF : default input count and debounce length
//   SW_MASK_MAX              : widest mask prio_enc accepts (N_IN must not exceed it)
//   prio_enc()               : index of the highest set bit of a mask, 0 if empty
package switch_enc_pkg;

    localparam int SW_N_IN_DEF = 4;
    localparam int SW_DEB_DEF  = 4;
    localparam int SW_MASK_MAX = 64;

    function automatic int prio_enc(input logic [SW_MASK_MAX-1:0] mask);
        int idx;
        idx = 0;
        for (int i = 0; i < SW_MASK_MAX; i++) begin
            if (mask[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/switch_encoder_if.sv
// Event/status bus between the switch encoder and the vending FSM.
//   out_valid : at least one event pending
//   out_code  : index of the highest pending event
//   out_ready : consumer accepts out_code this cycle
//   multi     : two or more events pending
//   overflow  : sticky lost-event flag
//   err_clr   : clears overflow
// master = encoder side, slave = consumer side.
interface switch_encoder_if #(
    parameter int W = 2
);
    logic         out_valid;
    logic [W-1:0] out_code;
    logic         out_ready;
    logic         multi;
    logic         overflow;
    logic         err_clr;

    modport master (
        output out_valid, out_code, multi, overflow,
        input  out_ready, err_clr
    );

    modport slave (
        input  out_valid, out_code, multi, overflow,
        output out_ready, err_clr
    );
endinterface

// File: rtl/switch_encoder_debounce.sv
// switch_debounce: two-flop synchroniser plus debouncer for one raw input.
//   clk, reset : clock, synchronous active-high reset
//   sw_raw     : raw asynchronous switch level
//   deb        : debounced level
//   rise       : high for the one cycle before deb goes 0->1, so the
//                consumer flop updates on the same edge as deb
module switch_debounce
    import switch_enc_pkg::*;
#(
    parameter int DEB_CYCLES = SW_DEB_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic deb,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1_q,  s1_d;
    logic          s2_q,  s2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_done;

    assign cnt_done = (cnt_q == CW'(DEB_CYCLES - 1));

    always_comb begin
        s1_d  = sw_raw;
        s2_d  = s1_q;
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (s2_q == deb_q) begin
            // any bounce back to the current level restarts the count
            cnt_d = '0;
        end else if (cnt_done) begin
            deb_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb  = deb_q;
    assign rise = s2_q & ~deb_q & cnt_done;

endmodule

// File: rtl/switch_encoder.sv
// switch_encoder: debounces N_IN raw switches, queues each debounced rising
// edge as a pending event and hands them out highest index first over a
// valid/ready handshake.
//   clk, reset : clock, synchronous active-high reset
//   sw_raw     : raw asynchronous switch levels
//   bus        : event/status bus (master side), see switch_encoder_if
// N_IN must be in 2..SW_MASK_MAX, DEB_CYCLES >= 1.
module switch_encoder
    import switch_enc_pkg::*;
#(
    parameter int N_IN       = SW_N_IN_DEF,
    parameter int DEB_CYCLES = SW_DEB_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IN-1:0]   sw_raw,
    switch_encoder_if.master  bus
);

    localparam int W = $clog2(N_IN);

    logic [N_IN-1:0]        rise;
    logic [N_IN-1:0]        unused_deb;
    logic [N_IN-1:0]        pend_q, pend_d;
    logic                   overflow_q, overflow_d;
    logic [N_IN-1:0]        clr;
    logic [SW_MASK_MAX-1:0] pend_ext;
    logic                   valid;
    logic [W-1:0]           code;

    for (genvar i = 0; i < N_IN; i++) begin : g_deb
        switch_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .sw_raw (sw_raw[i]),
            .deb    (unused_deb[i]),
            .rise   (rise[i])
        );
    end

    // Output decode from registered state only; out_ready never reaches it.
    always_comb begin
        pend_ext           = '0;
        pend_ext[N_IN-1:0] = pend_q;
        valid              = |pend_q;
        code               = W'(prio_enc(pend_ext));
    end

    always_comb begin
        clr = '0;
        if (valid && bus.out_ready) clr[code] = 1'b1;
        // a new rise on a bit being accepted re-arms it
        pend_d     = rise | (pend_q & ~clr);
        // a rise is only lost if its bit is still pending after this cycle
        overflow_d = (|(rise & pend_q & ~clr)) | (overflow_q & ~bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.out_valid = valid;
    assign bus.out_code  = code;
    assign bus.multi     = |(pend_q & (pend_q - N_IN'(1)));
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_switch_encoder.sv
module tb_switch_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw_raw;
    logic [7:0] sw_raw8;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    switch_encoder_if #(.W(2)) bus4 ();
    switch_encoder_if #(.W(3)) bus8 ();

    switch_encoder #(.N_IN(4), .DEB_CYCLES(4)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .sw_raw (sw_raw),
        .bus    (bus4)
    );

    switch_encoder #(.N_IN(8), .DEB_CYCLES(1)) u_dut8 (
        .clk    (clk),
        .reset  (reset),
        .sw_raw (sw_raw8),
        .bus    (bus8)
    );

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        sw_raw         = 4'b0000;
        sw_raw8        = 8'h00;
        bus4.out_ready = 1'b0;
        bus4.err_clr   = 1'b0;
        bus8.out_ready = 1'b0;
        bus8.err_clr   = 1'b0;
        step(3);
        chk("rst_valid", bus4.out_valid, 0);
        chk("rst_code",  bus4.out_code,  0);
        chk("rst_multi", bus4.multi,     0);
        chk("rst_ovf",   bus4.overflow,  0);
        chk("rst_valid8", bus8.out_valid, 0);
        reset = 1'b0;
        step(2);

        // clean press: edge 0 is the next edge
        sw_raw = 4'b0100;
        for (int e = 0; e < 5; e++) begin
            step();
            chk("press_early", bus4.out_valid, 0);
        end
        step();
        chk("press_valid", bus4.out_valid, 1);
        chk("press_code",  bus4.out_code,  2);
        chk("press_multi", bus4.multi,     0);
        bus4.out_ready = 1'b1;
        step();
        bus4.out_ready = 1'b0;
        chk("press_accept", bus4.out_valid, 0);
        sw_raw = 4'b0000;
        step(8);
        chk("release_no_evt", bus4.out_valid, 0);

        // bounce: 1,0,1,0 then hold 1; final 0->1 sample at the 5th edge
        sw_raw = 4'b0010; step();
        sw_raw = 4'b0000; step();
        sw_raw = 4'b0010; step();
        sw_raw = 4'b0000; step();
        sw_raw = 4'b0010; step();
        for (int e = 1; e < 5; e++) begin
            step();
            chk("bounce_early", bus4.out_valid, 0);
        end
        step();
        chk("bounce_valid", bus4.out_valid, 1);
        chk("bounce_code",  bus4.out_code,  1);
        bus4.out_ready = 1'b1;
        step();
        bus4.out_ready = 1'b0;
        step(6);
        chk("bounce_single", bus4.out_valid, 0);
        sw_raw = 4'b0000;
        step(8);

        // simultaneous presses drained back to back
        sw_raw         = 4'b1011;
        bus4.out_ready = 1'b1;
        step(5);
        chk("sim_early", bus4.out_valid, 0);
        step();
        chk("sim_v0", bus4.out_valid, 1);
        chk("sim_c0", bus4.out_code,  3);
        chk("sim_m0", bus4.multi,     1);
        step();
        chk("sim_c1", bus4.out_code,  1);
        chk("sim_m1", bus4.multi,     1);
        step();
        chk("sim_v2", bus4.out_valid, 1);
        chk("sim_c2", bus4.out_code,  0);
        chk("sim_m2", bus4.multi,     0);
        step();
        chk("sim_empty", bus4.out_valid, 0);
        chk("sim_ovf",   bus4.overflow,  0);
        bus4.out_ready = 1'b0;
        sw_raw         = 4'b0000;
        step(8);

        // overflow: press, release, re-press input 0 without accepting
        sw_raw = 4'b0001; step(6);
        chk("ovf_first", bus4.out_valid, 1);
        sw_raw = 4'b0000; step(8);
        sw_raw = 4'b0001; step(5);
        chk("ovf_before", bus4.overflow, 0);
        step();
        chk("ovf_set",   bus4.overflow,  1);
        chk("ovf_valid", bus4.out_valid, 1);
        chk("ovf_code",  bus4.out_code,  0);
        bus4.err_clr = 1'b1;
        step();
        bus4.err_clr = 1'b0;
        chk("ovf_clr",       bus4.overflow,  0);
        chk("ovf_clr_valid", bus4.out_valid, 1);
        step(3);
        chk("ovf_stays_clr", bus4.overflow, 0);
        // input 0 still pending; release then re-press and accept on its rise
        sw_raw = 4'b0000; step(8);
        sw_raw = 4'b0001; step(5);
        bus4.out_ready = 1'b1;
        step();
        bus4.out_ready = 1'b0;
        chk("setwin_valid", bus4.out_valid, 1);
        chk("setwin_code",  bus4.out_code,  0);
        chk("setwin_ovf",   bus4.overflow,  0);
        bus4.out_ready = 1'b1;
        step();
        bus4.out_ready = 1'b0;
        chk("setwin_drain", bus4.out_valid, 0);
        sw_raw = 4'b0000; step(8);

        // reset at edge 3 of a debounce restarts it from scratch
        sw_raw = 4'b0100; step(3);
        reset = 1'b1; step();
        reset = 1'b0;
        chk("mrst_valid", bus4.out_valid, 0);
        chk("mrst_code",  bus4.out_code,  0);
        chk("mrst_multi", bus4.multi,     0);
        chk("mrst_ovf",   bus4.overflow,  0);
        for (int e = 0; e < 5; e++) begin
            step();
            chk("mrst_early", bus4.out_valid, 0);
        end
        step();
        chk("mrst_valid_late", bus4.out_valid, 1);
        chk("mrst_code_late",  bus4.out_code,  2);

        // two events pending, then reset discards both
        sw_raw = 4'b0110; step(6);
        chk("two_multi", bus4.multi,    1);
        chk("two_code",  bus4.out_code, 2);
        sw_raw = 4'b0000;
        reset  = 1'b1; step();
        reset  = 1'b0;
        chk("two_rst_valid", bus4.out_valid, 0);
        chk("two_rst_multi", bus4.multi,     0);
        step(8);
        chk("two_rst_gone", bus4.out_valid, 0);

        // 8 inputs, single-cycle debounce
        sw_raw8 = 8'h80;
        step();
        chk("p8_e0", bus8.out_valid, 0);
        step();
        chk("p8_e1", bus8.out_valid, 0);
        step();
        chk("p8_valid", bus8.out_valid, 1);
        chk("p8_code",  bus8.out_code,  7);
        chk("p8_multi", bus8.multi,     0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
